// File: rtl/feed_batch_dispatcher.sv
// Packs up to three extractor messages into parser lanes 1..3 and presents the batch
// with a lane-valid mask until the parser stage accepts it.
module feed_batch_dispatcher #(
  parameter int DATA_W  = 264,
  parameter int TIMEOUT = 16,
  parameter int BCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] msg_in,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic              flush,
  input  logic              stage_ready,
  output logic [DATA_W-1:0] original_data_1,
  output logic [DATA_W-1:0] original_data_2,
  output logic [DATA_W-1:0] original_data_3,
  output logic [2:0]        lane_valid,
  output logic              message_en_out,
  output logic [BCNT_W-1:0] batch_cnt
);

  typedef enum logic {FILL, ISSUE} state_t;

  localparam logic [7:0] T_MAX = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [1:0] count;
  logic [7:0] timer;
  logic       accept, expire, go_issue, transfer;

  assign msg_ready = (state == FILL);

  always_comb begin
    state_next = state;
    accept     = msg_valid && msg_ready;
    // an accept restarts the idle window, so it masks a coincident expiry
    expire     = (count != 2'd0) && !accept && (timer == T_MAX);
    go_issue   = (accept && (count == 2'd2)) || expire ||
                 (flush && ((count != 2'd0) || accept));
    transfer   = (state == ISSUE) && message_en_out && stage_ready;
    case (state)
      FILL:    if (go_issue) state_next = ISSUE;
      ISSUE:   if (transfer) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count           <= '0;
      timer           <= '0;
      original_data_1 <= '0;
      original_data_2 <= '0;
      original_data_3 <= '0;
      lane_valid      <= '0;
      message_en_out  <= 1'b0;
      batch_cnt       <= '0;
    end else if (transfer) begin
      count           <= '0;
      timer           <= '0;
      original_data_1 <= '0;
      original_data_2 <= '0;
      original_data_3 <= '0;
      lane_valid      <= '0;
      message_en_out  <= 1'b0;
      batch_cnt       <= batch_cnt + BCNT_W'(1);
    end else if (state == FILL) begin
      if (accept) begin
        case (count)
          2'd0: begin
            original_data_1 <= msg_in;
            lane_valid      <= 3'b001;
          end
          2'd1: begin
            original_data_2 <= msg_in;
            lane_valid      <= 3'b011;
          end
          2'd2: begin
            original_data_3 <= msg_in;
            lane_valid      <= 3'b111;
          end
          default: ;
        endcase
        count <= count + 2'd1;
        timer <= '0;
      end else if (((count == 2'd1) || (count == 2'd2)) && (timer != T_MAX)) begin
        timer <= timer + 8'd1;
      end
      message_en_out <= go_issue;
    end
  end

endmodule

// File: tb/tb_feed_batch_dispatcher.sv
// Scenario bench for feed_batch_dispatcher: expected batches are queued as stimulus is
// driven and checked by a monitor whenever a batch transfers to the parser stage.
module tb_feed_batch_dispatcher;

  localparam int DW = 264;

  typedef struct {
    logic [DW-1:0] d1, d2, d3;
    logic [2:0]    lv;
  } batch_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] msg_in;
  logic          msg_valid, flush, stage_ready;
  logic          msg_ready, message_en_out;
  logic [DW-1:0] original_data_1, original_data_2, original_data_3;
  logic [2:0]    lane_valid;
  logic [15:0]   batch_cnt;

  logic [DW-1:0] min2;
  logic          mv2, fl2, sr2, mr2, en2;
  logic [DW-1:0] o21, o22, o23;
  logic [2:0]    lv2;
  logic [3:0]    cnt2;

  batch_t      sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  feed_batch_dispatcher #(.DATA_W(DW), .TIMEOUT(16), .BCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .msg_in(msg_in), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .flush(flush), .stage_ready(stage_ready),
    .original_data_1(original_data_1), .original_data_2(original_data_2),
    .original_data_3(original_data_3), .lane_valid(lane_valid),
    .message_en_out(message_en_out), .batch_cnt(batch_cnt)
  );

  feed_batch_dispatcher #(.DATA_W(DW), .TIMEOUT(16), .BCNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .msg_in(min2), .msg_valid(mv2),
    .msg_ready(mr2), .flush(fl2), .stage_ready(sr2),
    .original_data_1(o21), .original_data_2(o22), .original_data_3(o23),
    .lane_valid(lv2), .message_en_out(en2), .batch_cnt(cnt2)
  );

  always @(negedge clk) begin : monitor
    batch_t e;
    if (rst_n && message_en_out && stage_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: batch lane_valid=%b transferred, required no batch", lane_valid);
      end else begin
        e = sb.pop_front();
        if (lane_valid !== e.lv) begin
          n_err++;
          $display("FAIL sb_lane_valid: got %b required %b", lane_valid, e.lv);
        end
        n_cmp++;
        if (original_data_1 !== e.d1) begin
          n_err++;
          $display("FAIL sb_lane1: got %h required %h", original_data_1, e.d1);
        end
        n_cmp++;
        if (original_data_2 !== e.d2) begin
          n_err++;
          $display("FAIL sb_lane2: got %h required %h", original_data_2, e.d2);
        end
        n_cmp++;
        if (original_data_3 !== e.d3) begin
          n_err++;
          $display("FAIL sb_lane3: got %h required %h", original_data_3, e.d3);
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_msg();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r = {r[DW-33:0], $urandom()};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_batch(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                            input logic [DW-1:0] d3, input logic [2:0] lv);
    batch_t b;
    b.d1 = d1; b.d2 = d2; b.d3 = d3; b.lv = lv;
    sb.push_back(b);
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; msg_in = '0; msg_valid = 1'b0; flush = 1'b0; stage_ready = 1'b0;
    min2 = '0; mv2 = 1'b0; fl2 = 1'b0; sr2 = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({message_en_out, lane_valid, batch_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got en=%b lv=%b cnt=%0d required 0/000/0",
               message_en_out, lane_valid, batch_cnt);
    end
    n_cmp++;
    if ({original_data_1, original_data_2, original_data_3} !== '0) begin
      n_err++;
      $display("FAIL reset_lanes: got nonzero lane data, required all zero");
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (msg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b required 1", msg_ready);
    end
  endtask

  task automatic test_empty_flush();
    flush = 1'b1; stage_ready = 1'b1;
    repeat (3) step();
    flush = 1'b0;
    n_cmp++;
    if ({message_en_out, lane_valid} !== 4'b0000 || batch_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL empty_flush: got en=%b lv=%b cnt=%0d required 0/000/0",
               message_en_out, lane_valid, batch_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a, b, c;
    a = rnd_msg(); b = rnd_msg(); c = rnd_msg();
    push_batch(a, b, c, 3'b111);
    stage_ready = 1'b1; msg_valid = 1'b1;
    msg_in = a; step();
    msg_in = b; step();
    n_cmp++;
    if (message_en_out !== 1'b0 || lane_valid !== 3'b011) begin
      n_err++;
      $display("FAIL b2b_fill: got en=%b lv=%b required 0/011", message_en_out, lane_valid);
    end
    msg_in = c; step();
    msg_valid = 1'b0;
    n_cmp++;
    if (message_en_out !== 1'b1 || msg_ready !== 1'b0 || lane_valid !== 3'b111) begin
      n_err++;
      $display("FAIL b2b_issue: got en=%b ready=%b lv=%b required 1/0/111",
               message_en_out, msg_ready, lane_valid);
    end
    step();
    n_cmp++;
    if (message_en_out !== 1'b0 || msg_ready !== 1'b1 || lane_valid !== 3'b000 ||
        batch_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL b2b_done: got en=%b ready=%b lv=%b cnt=%0d required 0/1/000/%0d",
               message_en_out, msg_ready, lane_valid, batch_cnt, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] a;
    int unsigned early;
    a = rnd_msg();
    push_batch(a, '0, '0, 3'b001);
    stage_ready = 1'b1; msg_valid = 1'b1; msg_in = a;
    step();
    msg_valid = 1'b0;
    early = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (message_en_out !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_err++;
      $display("FAIL timeout_early: en high in %0d of 15 idle cycles, required 0", early);
    end
    step();
    n_cmp++;
    if (message_en_out !== 1'b1 || lane_valid !== 3'b001) begin
      n_err++;
      $display("FAIL timeout_issue: got en=%b lv=%b required 1/001", message_en_out, lane_valid);
    end
    step();
    n_cmp++;
    if (batch_cnt !== exp_cnt || message_en_out !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_done: got cnt=%0d en=%b required %0d/0",
               batch_cnt, message_en_out, exp_cnt);
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] a, b;
    a = rnd_msg(); b = rnd_msg();
    push_batch(a, b, '0, 3'b011);
    stage_ready = 1'b1; msg_valid = 1'b1;
    msg_in = a; step();
    msg_in = b; step();
    msg_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (message_en_out !== 1'b1 || lane_valid !== 3'b011) begin
      n_err++;
      $display("FAIL flush_issue: got en=%b lv=%b required 1/011", message_en_out, lane_valid);
    end
    step();
    n_cmp++;
    if (batch_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL flush_cnt: got %0d required %0d", batch_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] a, b, c;
    int unsigned bad;
    a = rnd_msg(); b = rnd_msg(); c = rnd_msg();
    push_batch(a, b, c, 3'b111);
    stage_ready = 1'b0; msg_valid = 1'b1;
    msg_in = a; step();
    msg_in = b; step();
    msg_in = c; step();
    msg_in = rnd_msg();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (message_en_out !== 1'b1 || msg_ready !== 1'b0 || lane_valid !== 3'b111 ||
          original_data_1 !== a || original_data_2 !== b || original_data_3 !== c) bad++;
      if (i < 5) step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_hold: batch disturbed in %0d of 6 cycles, required 0", bad);
    end
    stage_ready = 1'b1;
    step();
    msg_valid = 1'b0;
    n_cmp++;
    if (message_en_out !== 1'b0 || lane_valid !== 3'b000 || batch_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL stall_release: got en=%b lv=%b cnt=%0d required 0/000/%0d",
               message_en_out, lane_valid, batch_cnt, exp_cnt);
    end
  endtask

  task automatic test_accept_at_expiry();
    logic [DW-1:0] a, b;
    int unsigned early;
    a = rnd_msg(); b = rnd_msg();
    push_batch(a, b, '0, 3'b011);
    stage_ready = 1'b1; msg_valid = 1'b1; msg_in = a;
    step();
    msg_valid = 1'b0;
    repeat (15) step();
    msg_valid = 1'b1; msg_in = b;
    step();
    msg_valid = 1'b0;
    n_cmp++;
    if (message_en_out !== 1'b0 || lane_valid !== 3'b011) begin
      n_err++;
      $display("FAIL expiry_accept: got en=%b lv=%b required 0/011", message_en_out, lane_valid);
    end
    early = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (message_en_out !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_err++;
      $display("FAIL expiry_restart: en high in %0d of 15 cycles, required 0", early);
    end
    step();
    n_cmp++;
    if (message_en_out !== 1'b1 || lane_valid !== 3'b011) begin
      n_err++;
      $display("FAIL expiry_issue: got en=%b lv=%b required 1/011", message_en_out, lane_valid);
    end
    step();
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] c;
    stage_ready = 1'b1; msg_valid = 1'b1;
    msg_in = rnd_msg(); step();
    msg_in = rnd_msg(); step();
    msg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    n_cmp++;
    if ({message_en_out, lane_valid, batch_cnt} !== '0 ||
        {original_data_1, original_data_2, original_data_3} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got en=%b lv=%b cnt=%0d required all zero",
               message_en_out, lane_valid, batch_cnt);
    end
    step();
    rst_n = 1'b1;
    c = rnd_msg();
    push_batch(c, '0, '0, 3'b001);
    msg_valid = 1'b1; flush = 1'b1; msg_in = c;
    step();
    msg_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (message_en_out !== 1'b1 || lane_valid !== 3'b001 || original_data_1 !== c) begin
      n_err++;
      $display("FAIL reset_restart: got en=%b lv=%b required 1/001 with lane1 = new message",
               message_en_out, lane_valid);
    end
    step();
    n_cmp++;
    if (batch_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d required %0d", batch_cnt, exp_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    min2 = rnd_msg(); mv2 = 1'b1; fl2 = 1'b1; sr2 = 1'b1;
    repeat (30) step();
    n_cmp++;
    if (cnt2 !== 4'd15) begin
      n_err++;
      $display("FAIL wrap_pre: got %0d required 15", cnt2);
    end
    repeat (2) step();
    mv2 = 1'b0; fl2 = 1'b0;
    n_cmp++;
    if (cnt2 !== 4'd0 || en2 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_zero: got cnt=%0d en=%b required 0/0", cnt2, en2);
    end
  endtask

  initial begin
    test_reset();
    test_empty_flush();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_stall();
    test_accept_at_expiry();
    test_mid_reset();
    test_cnt_wrap();
    repeat (2) step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d batches outstanding required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
